// File: rtl/time_field_adjust.sv
// Three-field (seconds/minutes/hours style) time adjuster with press-and-hold auto-repeat.
// Fields step up or down on the selected field, with optional carry chaining f0 -> f1 -> f2.
module time_field_adjust #(
  parameter int unsigned W       = 6,
  parameter int unsigned MOD0    = 60,
  parameter int unsigned MOD1    = 60,
  parameter int unsigned MOD2    = 24,
  parameter int unsigned REP_DLY = 8,
  parameter int unsigned REP_PER = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [1:0]   sel,
  input  logic         up,
  input  logic         down,
  input  logic         carry_en,
  input  logic         clr,
  output logic [W-1:0] f0,
  output logic [W-1:0] f1,
  output logic [W-1:0] f2,
  output logic         step,
  output logic         wrap
);

  localparam int unsigned RepMax = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int unsigned CntW   = $clog2(RepMax + 1);

  localparam logic [W-1:0]    Max0    = W'(MOD0 - 1);
  localparam logic [W-1:0]    Max1    = W'(MOD1 - 1);
  localparam logic [W-1:0]    Max2    = W'(MOD2 - 1);
  localparam logic [CntW-1:0] DlyLast = CntW'(REP_DLY - 1);
  localparam logic [CntW-1:0] PerLast = CntW'(REP_PER - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            dir_q, dir_d;
  logic [W-1:0]    f0_q, f0_d, f1_q, f1_d, f2_q, f2_d;
  logic            step_q, step_d, wrap_q, wrap_d;

  logic            cmd, do_step;
  logic            s0, s1, s2, w0, w1, w2;

  function automatic logic [W-1:0] next_val(input logic [W-1:0] v, input logic [W-1:0] maxv,
                                            input logic inc);
    if (inc) begin
      next_val = (v == maxv) ? '0 : v + 1'b1;
    end else begin
      next_val = (v == '0) ? maxv : v - 1'b1;
    end
  endfunction

  function automatic logic at_edge(input logic [W-1:0] v, input logic [W-1:0] maxv,
                                   input logic inc);
    at_edge = inc ? (v == maxv) : (v == '0);
  endfunction

  assign cmd = up ^ down;

  // Hold FSM; the latched sel/direction detect a change mid-hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    if (clr || !en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd && (sel != 2'd3)) begin
            do_step = 1'b1;
            state_d = StDelay;
            cnt_d   = '0;
            sel_d   = sel;
            dir_d   = up;
          end
        end
        StDelay, StRepeat: begin
          if (!cmd || (up != dir_q) || (sel != sel_q)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == StDelay) ? DlyLast : PerLast)) begin
            do_step = 1'b1;
            state_d = StRepeat;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Carry chain: a wrap on a lower field steps the next one in the same edge.
  always_comb begin
    s0 = do_step && (sel == 2'd0);
    w0 = s0 && at_edge(f0_q, Max0, up);
    s1 = do_step && ((sel == 2'd1) || (carry_en && w0));
    w1 = s1 && at_edge(f1_q, Max1, up);
    s2 = do_step && ((sel == 2'd2) || (carry_en && w1));
    w2 = s2 && at_edge(f2_q, Max2, up);

    f0_d   = s0 ? next_val(f0_q, Max0, up) : f0_q;
    f1_d   = s1 ? next_val(f1_q, Max1, up) : f1_q;
    f2_d   = s2 ? next_val(f2_q, Max2, up) : f2_q;
    step_d = do_step;
    wrap_d = w0 | w1 | w2;
    if (clr) begin
      f0_d   = '0;
      f1_d   = '0;
      f2_d   = '0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      dir_q   <= 1'b0;
      f0_q    <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign f0   = f0_q;
  assign f1   = f1_q;
  assign f2   = f2_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule
